fetch_sequencer: RTL

Instruction-fetch controller for the RV32IM core. It owns the architectural PC and sequences it: it issues one instruction-memory request per fetch and sequential-increments by 4. It takes branch/jump redirects from execute, diverts misaligned targets to a trap vector, and stops on halt. It sits between the instruction memory port and the decode stage, and presents fetched instructions through a one-entry valid/ready output buffer.

---
 rtl/fetch_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Purpose : instruction-fetch controller; owns the PC, issues one imem request per fetch, handles redirects, misaligned-target traps and halt.
// Latency : handshake in cycle n -> if_valid in n+1; redirect in cycle n -> imem_addr = target in n+1.
// Backpr. : one-entry output buffer; imem_req drops and the PC holds while if_valid && !id_ready.
//
// Ports:
//   clk, reset               single clock; synchronous active-low reset
//   imem_req/addr/ready/rdata instruction memory port (same-cycle response)
//   if_valid/instr/pc, id_ready  buffered instruction toward decode
//   redirect_valid/target    taken branch/jump from execute
//   halt                     stop fetching until reset
//   misalign_trap/addr       pulse + captured target for a misaligned redirect
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;

    logic buf_free;
    logic fetch_fire;
    logic redir_vld;
    logic redir_misaligned;

    // The buffer can take a new word if it is empty or being drained this cycle.
    assign buf_free         = !if_valid || id_ready;
    // Redirects are ignored once halted; only reset leaves HALTED.
    assign redir_vld        = redirect_valid && (state_q != S_HALTED);
    assign redir_misaligned = (redirect_target[1:0] != 2'b00);
    assign fetch_fire       = imem_req && imem_ready;
    assign imem_addr        = pc_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (halt) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: request depends only on state and buffer occupancy,
    // never on imem_ready.
    always_comb begin
        imem_req = 1'b0;
        if (state_q == S_FETCH && buf_free) begin
            imem_req = 1'b1;
        end
    end

    // PC, output buffer and trap capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_VECTOR;
            if_valid      <= 1'b0;
            if_instr      <= 32'h0;
            if_pc         <= 32'h0;
            misalign_trap <= 1'b0;
            misalign_addr <= 32'h0;
        end else begin
            misalign_trap <= 1'b0;
            if (redir_vld) begin
                // Flush: any word returned this cycle belongs to the old path.
                if_valid <= 1'b0;
                if (redir_misaligned) begin
                    pc_q          <= TRAP_VECTOR;
                    misalign_trap <= 1'b1;
                    misalign_addr <= redirect_target;
                end else begin
                    pc_q <= redirect_target;
                end
            end else if (fetch_fire) begin
                // Covers both fill-empty and replace-while-consuming.
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc_q;
                pc_q     <= pc_q + 32'd4;
            end else if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
